// File: rtl/cdrtrig_pkg.sv
// Shared 64b/66b constants and block types for the CDR trigger
// test-pattern transmit and receive paths.
package cdrtrig_pkg;

    localparam logic [1:0] HDR_DATA = 2'b01;
    localparam logic [1:0] HDR_CTL  = 2'b10;
    localparam logic [7:0] BLK_IDLE = 8'h1e;

    localparam int SCR_TAP_A = 38;
    localparam int SCR_TAP_B = 57;
    localparam int SCR_WIDTH = 58;

    localparam int BLK_W  = 66;
    localparam int WORD_W = 32;
    localparam int BUF_W  = 64;

    typedef logic [1:0] hdr_t;

    typedef struct packed {
        hdr_t        hdr;
        logic [63:0] data;
    } blk_t;

    function automatic logic [63:0] idle_payload(
        input logic [7:0] blk_type
    );
        return {blk_type, 56'h0};
    endfunction

endpackage

// File: rtl/tx_64b66b_framer_if.sv
// Valid/ready block stream into the 64b/66b framer.
// The framer side is the slave; upstream is the master.
interface tx_64b66b_framer_if;
    import cdrtrig_pkg::*;

    logic        blk_valid;
    logic        blk_ready;
    hdr_t        blk_header;
    logic [63:0] blk_data;

    modport master (
        output blk_valid,
        output blk_header,
        output blk_data,
        input  blk_ready
    );

    modport slave (
        input  blk_valid,
        input  blk_header,
        input  blk_data,
        output blk_ready
    );

endinterface

// File: rtl/tx_64b66b_framer_scrambler.sv
// Self-synchronous x^58+x^39+1 scrambler, 64 bits per call, bit 63 first.
// State only moves when the caller commits a block.
module Scrambler64b66b
    import cdrtrig_pkg::*;
#(
    parameter logic [SCR_WIDTH-1:0] INIT = '1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance,
    input  logic [63:0] din,
    output logic [63:0] dout
);

    logic [SCR_WIDTH-1:0] state;
    logic [SCR_WIDTH-1:0] state_next;

    always_comb begin : unroll
        logic [SCR_WIDTH-1:0] s;
        s    = state;
        dout = '0;
        for (int i = 63; i >= 0; i--) begin
            dout[i] = din[i] ^ s[SCR_TAP_A] ^ s[SCR_TAP_B];
            s       = {s[SCR_WIDTH-2:0], dout[i]};
        end
        state_next = s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
        end else if (advance) begin
            state <= state_next;
        end
    end

endmodule

// File: rtl/tx_64b66b_framer.sv
// 64b/66b transmit framer: hold register, scrambler and 66->32 gearbox.
// Idle control blocks are substituted whenever upstream has nothing ready.
module tx_64b66b_framer
    import cdrtrig_pkg::*;
#(
    parameter logic [7:0]           IDLE_TYPE     = BLK_IDLE,
    parameter logic [SCR_WIDTH-1:0] SCRAMBLE_INIT = '1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scramble_en,
    tx_64b66b_framer_if.slave     blk,
    output logic [WORD_W-1:0]     tx_data,
    output logic                  idle_inserted
);

    logic [BUF_W-1:0] sbuf;
    logic [6:0]       cnt;
    logic [6:0]       cnt_next;
    blk_t             hold;
    blk_t             hold_next;

    logic             consume;
    logic             accept;
    logic [63:0]      scr_in;
    logic [63:0]      scr_out;
    logic [95:0]      merged;

    assign consume = cnt < 7'd32;
    assign accept  = consume && blk.blk_valid && blk.blk_ready;

    assign scr_in = accept ? blk.blk_data : idle_payload(IDLE_TYPE);

    Scrambler64b66b #(
        .INIT (SCRAMBLE_INIT)
    ) u_scr (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (consume && scramble_en),
        .din     (scr_in),
        .dout    (scr_out)
    );

    always_comb begin
        hold_next.hdr  = accept ? blk.blk_header : HDR_CTL;
        hold_next.data = scramble_en ? scr_out : scr_in;
    end

    // Leftover buffer bits sit on top; the hold block follows right behind them.
    assign merged = {sbuf, 32'h0}
                  | ({30'h0, hold} << (7'd30 - cnt));

    assign cnt_next = consume ? cnt + 7'd34 : cnt - 7'd32;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data       <= '0;
            sbuf          <= '0;
            cnt           <= '0;
            hold          <= '{hdr: HDR_CTL, data: 64'h0};
            blk.blk_ready <= 1'b0;
            idle_inserted <= 1'b0;
        end else begin
            cnt           <= cnt_next;
            blk.blk_ready <= cnt_next < 7'd32;
            idle_inserted <= consume && !accept;
            if (consume) begin
                tx_data <= merged[95:64];
                sbuf    <= merged[63:0];
                hold    <= hold_next;
            end else begin
                tx_data <= sbuf[63:32];
                sbuf    <= {sbuf[31:0], 32'h0};
            end
        end
    end

endmodule

// File: tb/tb_tx_64b66b_framer.sv
// Loopback bench: serial deserializer + descrambler rebuild blocks
// from tx_data and match them against accepted upstream blocks.
module tb_tx_64b66b_framer;
    import cdrtrig_pkg::*;

    localparam logic [65:0] IDLE_BLK = {HDR_CTL, BLK_IDLE, 56'h0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scramble_en = 1'b0;
    logic [31:0] tx_data;
    logic        idle_inserted;

    tx_64b66b_framer_if bus ();

    tx_64b66b_framer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .scramble_en   (scramble_en),
        .blk           (bus),
        .tx_data       (tx_data),
        .idle_inserted (idle_inserted)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    bit          bits_q[$];
    logic [65:0] exp_q[$];
    logic [65:0] rx_q[$];
    int          rx_idx_q[$];
    int          blk_no = 0;
    int          idle_rx = 0;
    int          acc_cnt = 0;
    int          ins_cnt = 0;
    logic [57:0] ds = '1;
    logic        run = 1'b0;
    logic [65:0] mon_blk;
    logic        mon_r;
    logic        prev_wait = 1'b0;
    logic [63:0] prev_data = '0;
    logic [63:0] cnt_data = '0;

    always @(posedge clk) run <= rst_n;

    always @(negedge clk) begin
        if (!rst_n) begin
            bits_q.delete();
            exp_q.delete();
            rx_q.delete();
            rx_idx_q.delete();
            blk_no = 0;
            ds = '1;
            prev_wait = 1'b0;
        end else if (run) begin
            if (prev_wait) begin
                compared++;
                if (bus.blk_valid !== 1'b1 || bus.blk_data !== prev_data) begin
                    mismatched++;
                    $display("FAIL hold_stable valid=%b data=%h want data=%h",
                             bus.blk_valid, bus.blk_data, prev_data);
                end
            end
            prev_wait = bus.blk_valid && !bus.blk_ready;
            prev_data = bus.blk_data;
            if (bus.blk_valid && bus.blk_ready) begin
                exp_q.push_back({bus.blk_header, bus.blk_data});
                acc_cnt++;
            end
            if (idle_inserted) ins_cnt++;
            for (int i = 31; i >= 0; i--) bits_q.push_back(tx_data[i]);
            if (bits_q.size() >= 66) begin
                for (int i = 65; i >= 0; i--) mon_blk[i] = bits_q.pop_front();
                if (blk_no != 0) begin
                    if (scramble_en) begin
                        for (int i = 63; i >= 0; i--) begin
                            mon_r = mon_blk[i];
                            mon_blk[i] = mon_r ^ ds[38] ^ ds[57];
                            ds = {ds[56:0], mon_r};
                        end
                    end
                    if (mon_blk == IDLE_BLK) begin
                        idle_rx++;
                    end else begin
                        rx_q.push_back(mon_blk);
                        rx_idx_q.push_back(blk_no);
                    end
                end
                blk_no++;
            end
        end
    end

    task automatic reset_dut(input int n);
        rst_n = 1'b0;
        @(negedge clk);
        compared++;
        if (tx_data !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_tx_data got %h want %h", tx_data, 32'h0);
        end
        compared++;
        if (bus.blk_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_blk_ready got %b want 0", bus.blk_ready);
        end
        compared++;
        if (idle_inserted !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_idle_inserted got %b want 0", idle_inserted);
        end
        repeat (n) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        compared++;
        if (tx_data !== 32'h8000_0000) begin
            mismatched++;
            $display("FAIL first_word got %h want %h", tx_data, 32'h8000_0000);
        end
        compared++;
        if (bus.blk_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL first_ready got %b want 0", bus.blk_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input int cycles, input int gap, input bit rnd);
        bit took;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            took = rst_n && bus.blk_valid && bus.blk_ready;
            @(posedge clk);
            #1;
            if (took) bus.blk_valid = 1'b0;
            if (!bus.blk_valid && (i % gap == 0)) begin
                bus.blk_valid  = 1'b1;
                bus.blk_header = HDR_DATA;
                bus.blk_data   = rnd ? {$urandom(), $urandom()} : cnt_data;
                cnt_data++;
            end
        end
    endtask

    task automatic drain(input int n);
        bit took;
        for (int k = 0; k < 40 && bus.blk_valid; k++) begin
            @(negedge clk);
            took = bus.blk_valid && bus.blk_ready;
            @(posedge clk);
            #1;
            if (took) bus.blk_valid = 1'b0;
        end
        compared++;
        if (bus.blk_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL drain_timeout valid=%b want 0", bus.blk_valid);
        end
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_idle_fill;
        int r0, i0, s0;
        scramble_en = 1'b1;
        bus.blk_valid = 1'b0;
        reset_dut(3);
        s0 = idle_rx;
        r0 = 0;
        i0 = 0;
        repeat (33) begin
            @(negedge clk);
            if (bus.blk_ready) r0++;
            if (idle_inserted) i0++;
        end
        compared++;
        if (r0 !== 16) begin
            mismatched++;
            $display("FAIL idle_ready_pulses got %0d want 16", r0);
        end
        compared++;
        if (i0 !== 16) begin
            mismatched++;
            $display("FAIL idle_inserted_pulses got %0d want 16", i0);
        end
        repeat (167) @(negedge clk);
        @(posedge clk);
        #1;
        compared++;
        if (rx_q.size() !== 0) begin
            mismatched++;
            $display("FAIL idle_nonidle_blocks got %0d want 0", rx_q.size());
        end
        compared++;
        if (idle_rx - s0 < 90) begin
            mismatched++;
            $display("FAIL idle_rx_count got %0d want >=90", idle_rx - s0);
        end
    endtask

    task automatic test_stream_scrambled;
        int a0, n0, s0;
        logic [65:0] got, want;
        scramble_en = 1'b1;
        reset_dut(3);
        cnt_data = '0;
        stream(40, 1, 1'b0);
        a0 = acc_cnt;
        n0 = ins_cnt;
        stream(33, 1, 1'b0);
        compared++;
        if (acc_cnt - a0 !== 16) begin
            mismatched++;
            $display("FAIL stream_accepts got %0d want 16", acc_cnt - a0);
        end
        compared++;
        if (ins_cnt - n0 !== 0) begin
            mismatched++;
            $display("FAIL stream_idles got %0d want 0", ins_cnt - n0);
        end
        stream(150, 1, 1'b0);
        drain(40);
        s0 = rx_q.size();
        compared++;
        if (s0 !== exp_q.size() || s0 < 80) begin
            mismatched++;
            $display("FAIL stream_count got %0d want %0d", s0, exp_q.size());
        end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got  = rx_q.pop_front();
            want = exp_q.pop_front();
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL stream_block got %h want %h", got, want);
            end
        end
    endtask

    task automatic test_single_raw;
        int pulses, gidx;
        bit took;
        logic [65:0] got;
        scramble_en = 1'b0;
        bus.blk_valid = 1'b0;
        reset_dut(3);
        pulses = 0;
        took = 1'b0;
        for (int i = 0; i < 60 && !took; i++) begin
            @(negedge clk);
            if (bus.blk_ready) pulses++;
            took = bus.blk_valid && bus.blk_ready;
            @(posedge clk);
            #1;
            if (took) begin
                bus.blk_valid = 1'b0;
            end else if (i == 10) begin
                bus.blk_valid  = 1'b1;
                bus.blk_header = HDR_DATA;
                bus.blk_data   = 64'h0123_4567_89ab_cdef;
            end
        end
        compared++;
        if (!took) begin
            mismatched++;
            $display("FAIL raw_accept_timeout got 0 want 1");
        end
        drain(20);
        compared++;
        if (rx_q.size() !== 1) begin
            mismatched++;
            $display("FAIL raw_block_count got %0d want 1", rx_q.size());
        end
        if (rx_q.size() > 0) begin
            got  = rx_q.pop_front();
            gidx = rx_idx_q.pop_front();
            compared++;
            if (got !== {HDR_DATA, 64'h0123_4567_89ab_cdef}) begin
                mismatched++;
                $display("FAIL raw_block got %h want %h", got,
                         {HDR_DATA, 64'h0123_4567_89ab_cdef});
            end
            compared++;
            if (gidx !== pulses + 1) begin
                mismatched++;
                $display("FAIL raw_offset got blk %0d want blk %0d",
                         gidx, pulses + 1);
            end
        end
    endtask

    task automatic test_sparse_random;
        int n0, s0;
        logic [65:0] got, want;
        scramble_en = 1'b1;
        reset_dut(3);
        n0 = ins_cnt;
        stream(300, 3, 1'b1);
        drain(40);
        compared++;
        if (ins_cnt - n0 < 10) begin
            mismatched++;
            $display("FAIL sparse_idles got %0d want >=10", ins_cnt - n0);
        end
        s0 = rx_q.size();
        compared++;
        if (s0 !== exp_q.size() || s0 < 50) begin
            mismatched++;
            $display("FAIL sparse_count got %0d want %0d", s0, exp_q.size());
        end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got  = rx_q.pop_front();
            want = exp_q.pop_front();
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL sparse_block got %h want %h", got, want);
            end
        end
    endtask

    task automatic test_mid_reset;
        int s0;
        logic [65:0] got, want;
        scramble_en = 1'b1;
        reset_dut(3);
        stream(18, 1, 1'b0);
        reset_dut(3);
        stream(150, 1, 1'b0);
        drain(40);
        s0 = rx_q.size();
        compared++;
        if (s0 !== exp_q.size() || s0 < 60) begin
            mismatched++;
            $display("FAIL relock_count got %0d want %0d", s0, exp_q.size());
        end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got  = rx_q.pop_front();
            want = exp_q.pop_front();
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL relock_block got %h want %h", got, want);
            end
        end
    endtask

    initial begin
        bus.blk_valid  = 1'b0;
        bus.blk_header = HDR_DATA;
        bus.blk_data   = '0;
        test_idle_fill();
        test_stream_scrambled();
        test_single_raw();
        test_sparse_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        mismatched++;
        $display("FAIL watchdog got timeout want finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $fatal(1, "watchdog");
    end

endmodule
